// File: rtl/aux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aux_arb_pkg
//  Purpose  : Shared types and helpers for the auxiliary-memory write arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package aux_arb_pkg;

    localparam int ARB_NUM_REQ = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    // Map a one-hot pick from the round-robin picker onto the grant state.
    function automatic arb_state_t pick_to_state(input logic [ARB_NUM_REQ-1:0] pick);
        arb_state_t st;
        st = ARB_IDLE;
        if (pick[0]) begin
            st = ARB_GRANT0;
        end else if (pick[1]) begin
            st = ARB_GRANT1;
        end
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aux_write_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Combinational two-way round-robin picker. On a tie the requester
//             that was not served last wins; a lone valid always wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick2
    import aux_arb_pkg::*;
(
    input  logic                   valid0_i,
    input  logic                   valid1_i,
    input  logic                   last_i,
    output logic [ARB_NUM_REQ-1:0] pick_o
);

    // Tie goes to the requester other than last_i; otherwise the lone valid wins.
    always_comb begin
        pick_o = 2'b00;
        if (valid0_i && valid1_i) begin
            pick_o = last_i ? 2'b01 : 2'b10;
        end else if (valid0_i) begin
            pick_o = 2'b01;
        end else if (valid1_i) begin
            pick_o = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aux_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aux_write_arbiter
//  Purpose  : Round-robin arbiter with bounded bursts for the single write
//             port of the auxiliary display memory. Requester 0 is the
//             CPU-snapshot stream, requester 1 the text/debug stream.
//  Options  : AUX_BLANK_GATE_EN - when defined, transfers only proceed while
//             blank_in is high; grant and burst count are frozen otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module aux_write_arbiter
    import aux_arb_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int AUX_ADDRESS_WIDTH = 5,
    parameter int BURST_MAX         = 4
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         blank_in,
    input  logic                         req0_valid_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] req0_address_in,
    input  logic [DATA_WIDTH-1:0]        req0_data_in,
    output logic                         req0_ready_out,
    input  logic                         req1_valid_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] req1_address_in,
    input  logic [DATA_WIDTH-1:0]        req1_data_in,
    output logic                         req1_ready_out,
    output logic [ARB_NUM_REQ-1:0]       grant_out,
    output logic                         aux_wr_out,
    output logic [AUX_ADDRESS_WIDTH-1:0] aux_waddress_out,
    output logic [DATA_WIDTH-1:0]        aux_data_out
);

    localparam int               CNT_W      = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_t             state_q, state_d;
    logic                   last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   w_gate;
    logic                   w_owner;
    logic                   w_own_valid;
    logic                   w_hs0, w_hs1, w_hs;
    logic                   w_release;
    logic [ARB_NUM_REQ-1:0] w_pick_idle;
    logic [ARB_NUM_REQ-1:0] w_pick_rel;

`ifdef AUX_BLANK_GATE_EN
    assign w_gate = blank_in;
`else
    // Gate permanently open; blank_in has no effect in this build.
    logic w_unused_blank;
    assign w_unused_blank = blank_in;
    assign w_gate         = 1'b1;
`endif

    // Ready comes from registered state and the gate only, never from valid.
    assign req0_ready_out = (state_q == ARB_GRANT0) && w_gate;
    assign req1_ready_out = (state_q == ARB_GRANT1) && w_gate;
    assign grant_out      = {state_q == ARB_GRANT1, state_q == ARB_GRANT0};

    assign w_hs0       = req0_valid_in && req0_ready_out;
    assign w_hs1       = req1_valid_in && req1_ready_out;
    assign w_hs        = w_hs0 || w_hs1;
    assign w_owner     = (state_q == ARB_GRANT1);
    assign w_own_valid = w_owner ? req1_valid_in : req0_valid_in;
    assign w_release   = (w_hs && (cnt_q == BURST_LAST)) || !w_own_valid;

    // Idle arbitration uses the stored last owner.
    rr_pick2 u_pick_idle (
        .valid0_i (req0_valid_in),
        .valid1_i (req1_valid_in),
        .last_i   (last_q),
        .pick_o   (w_pick_idle)
    );

    // On release the current owner becomes "last", so the other side wins a
    // tie and the owner only keeps the port when it is alone.
    rr_pick2 u_pick_rel (
        .valid0_i (req0_valid_in),
        .valid1_i (req1_valid_in),
        .last_i   (w_owner),
        .pick_o   (w_pick_rel)
    );

    // Next-state: idle arbitration, burst counting and release handling.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                cnt_d   = '0;
                state_d = pick_to_state(w_pick_idle);
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (w_gate) begin
                    if (w_release) begin
                        last_d  = w_owner;
                        cnt_d   = '0;
                        state_d = pick_to_state(w_pick_rel);
                    end else if (w_hs) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered write port: one strobe per handshake, address/data held between writes.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            aux_wr_out       <= 1'b0;
            aux_waddress_out <= '0;
            aux_data_out     <= '0;
        end else begin
            aux_wr_out <= w_hs;
            if (w_hs0) begin
                aux_waddress_out <= req0_address_in;
                aux_data_out     <= req0_data_in;
            end else if (w_hs1) begin
                aux_waddress_out <= req1_address_in;
                aux_data_out     <= req1_data_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aux_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aux_write_arbiter
//  Purpose  : Self-checking bench for aux_write_arbiter: directed scenarios
//             followed by randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aux_write_arbiter;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int BM = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    logic          clk = 1'b0;
    logic          rst, blank, v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          r0, r1, wr;
    logic [1:0]    grant;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    always #5 clk = ~clk;

    aux_write_arbiter #(
        .DATA_WIDTH        (DW),
        .AUX_ADDRESS_WIDTH (AW),
        .BURST_MAX         (BM)
    ) dut (
        .clock_in         (clk),
        .reset_in         (rst),
        .blank_in         (blank),
        .req0_valid_in    (v0),
        .req0_address_in  (a0),
        .req0_data_in     (d0),
        .req0_ready_out   (r0),
        .req1_valid_in    (v1),
        .req1_address_in  (a1),
        .req1_data_in     (d1),
        .req1_ready_out   (r1),
        .grant_out        (grant),
        .aux_wr_out       (wr),
        .aux_waddress_out (waddr),
        .aux_data_out     (wdata)
    );

    int checks = 0;
    int errors = 0;

    // Requester queues and observed write-address log.
    item_t q0[$];
    item_t q1[$];
    int    wlog[$];

    // Behavioural model: current owner (-1 = nobody), last served, burst length so far.
    int            m_owner = -1;
    int            m_last  = 1;
    int            m_burst = 0;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        if (v0) begin a0 = q0[0].a; d0 = q0[0].d; end
        if (v1) begin a1 = q1[0].a; d1 = q1[0].d; end
    endtask

    // One clock cycle: compare against the model, advance the model, then let
    // the requesters react to the handshake they observed.
    task automatic cycle();
        logic g, er0, er1, hs0, hs1, hs, seen0, seen1;
        logic [1:0] vv;
        int k;
        @(negedge clk);
`ifdef AUX_BLANK_GATE_EN
        g = blank;
`else
        g = 1'b1;
`endif
        er0 = (m_owner == 0) && g;
        er1 = (m_owner == 1) && g;
        chk("grant", 32'(grant), (m_owner == 0) ? 32'd1 : (m_owner == 1) ? 32'd2 : 32'd0);
        chk("ready0", 32'(r0), 32'(er0));
        chk("ready1", 32'(r1), 32'(er1));
        chk("aux_wr", 32'(wr), 32'(m_wr));
        chk("aux_addr", 32'(waddr), 32'(m_addr));
        chk("aux_data", 32'(wdata), 32'(m_data));
        if (wr === 1'b1) wlog.push_back(int'(waddr));
        seen0 = r0;
        seen1 = r1;
        hs0 = er0 && v0;
        hs1 = er1 && v1;
        hs  = hs0 || hs1;
        vv  = {v1, v0};
        if (rst) begin
            m_owner = -1; m_last = 1; m_burst = 0;
            m_wr = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            m_wr = hs;
            if (hs0) begin m_addr = a0; m_data = d0; end
            else if (hs1) begin m_addr = a1; m_data = d1; end
            if (m_owner < 0) begin
                if (v0 && v1)  m_owner = 1 - m_last;
                else if (v0)   m_owner = 0;
                else if (v1)   m_owner = 1;
                m_burst = 0;
            end else if (g) begin
                k = m_owner;
                if ((hs && (m_burst + 1 == BM)) || !vv[k]) begin
                    m_last  = k;
                    m_burst = 0;
                    if (vv[1-k])    m_owner = 1 - k;
                    else if (vv[k]) m_owner = k;
                    else            m_owner = -1;
                end else if (hs) begin
                    m_burst++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            if (seen0 && v0) void'(q0.pop_front());
            if (seen1 && v1) void'(q1.pop_front());
        end
        drive();
    endtask

    initial begin
        rst = 1'b1; blank = 1'b1;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        @(posedge clk);
        #1;
        repeat (2) cycle();
        rst = 1'b0;

        // Single request from idle: ready one cycle later, write the cycle after.
        q0.push_back('{5'd3, 16'h1234});
        drive();
        cycle();
        chk("t1_ready0", 32'(r0), 32'd1);
        chk("t1_grant", 32'(grant), 32'd1);
        cycle();
        chk("t1_wr", 32'(wr), 32'd1);
        chk("t1_addr", 32'(waddr), 32'd3);
        chk("t1_data", 32'(wdata), 32'h1234);
        repeat (3) cycle();

        // Fresh reset, then both streaming: bursts of BM alternate, requester 0 first.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wlog.delete();
        for (int i = 0; i < 12; i++) begin
            q0.push_back('{AW'(i), DW'(16'h0a00 + i)});
            q1.push_back('{AW'(16 + i), DW'(16'h0b00 + i)});
        end
        drive();
        repeat (30) cycle();
        chk("t2_count", 32'(wlog.size()), 32'd24);
        for (int i = 0; i < 24; i++) begin
            if (i < wlog.size())
                chk("t2_owner", 32'(wlog[i] >= 16), 32'((i / BM) % 2));
        end

        // Lone requester 1 write, then both again: requester 0 wins the tie.
        q1.push_back('{5'd20, 16'hbeef});
        drive();
        repeat (6) cycle();
        wlog.delete();
        q0.push_back('{5'd1, 16'h0001});
        q1.push_back('{5'd21, 16'h0021});
        drive();
        repeat (8) cycle();
        chk("t3_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() != 0) chk("t3_first", 32'(wlog[0]), 32'd1);

        // Reset during the second handshake of a burst; the dropped write is re-presented.
        wlog.delete();
        for (int i = 0; i < 4; i++) q0.push_back('{AW'(8 + i), DW'(16'h0c00 + i)});
        drive();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_wr", 32'(wr), 32'd0);
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_ready0", 32'(r0), 32'd0);
        chk("t5_ready1", 32'(r1), 32'd0);
        repeat (10) cycle();
        chk("t5_count", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) chk("t5_addr", 32'(wlog[i]), 32'(8 + i));
        end

        // Randomized traffic, blanking and occasional resets.
        for (int n = 0; n < 600; n++) begin
            if (q0.size() < 3 && $urandom_range(0, 2) == 0)
                q0.push_back('{AW'($urandom), DW'($urandom)});
            if (q1.size() < 3 && $urandom_range(0, 2) == 0)
                q1.push_back('{AW'($urandom), DW'($urandom)});
            drive();
            blank = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
